traj_sequencer: RTL and testbench

Motion-source controller for the arm's x/y/z servo setpoint path. Selects between home position, live accelerometer pass-through, and recording accelerometer samples into a trajectory RAM at a fixed rate. Also replays the stored trajectory in a continuous loop, one point per dwell period. Drives the external synchronous trajectory RAM and the servo setpoint registers.

---
 rtl/traj_pkg.sv | 16 +
 rtl/dwell_timer.sv | 27 ++
 rtl/traj_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_traj_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/traj_pkg.sv
// Shared types and constants for the trajectory sequencer.
package traj_pkg;

  localparam int AXIS_W   = 8;
  localparam int HOME_POS = 50;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LIVE   = 3'd1,
    S_RECORD = 3'd2,
    S_FETCH  = 3'd3,
    S_LOAD   = 3'd4,
    S_HOLD   = 3'd5
  } state_t;

endpackage

// File: rtl/dwell_timer.sv
// Dwell period timer: counts 0..DWELL-1 while enabled, pulses tick on the
// last count and wraps. clr restarts the period (used on every state entry).
module dwell_timer #(
  parameter int DWELL = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(DWELL);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == CW'(DWELL - 1));

  // Period counter; clear has priority over counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (tick) cnt <= '0;
    else if (en)   cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/traj_sequencer.sv
// Motion-source controller: home / live accelerometer / record to RAM /
// looped playback from RAM, driving servo setpoints and the trajectory RAM.
module traj_sequencer
  import traj_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DWELL  = 50000,
  parameter int HOME   = HOME_POS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              btn_rec,
  input  logic              btn_mem,
  input  logic [AXIS_W-1:0] accel_x,
  input  logic [AXIS_W-1:0] accel_y,
  input  logic [AXIS_W-1:0] accel_z,
  input  logic [AXIS_W-1:0] mem_rdata_x,
  input  logic [AXIS_W-1:0] mem_rdata_y,
  input  logic [AXIS_W-1:0] mem_rdata_z,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [AXIS_W-1:0] mem_wdata_x,
  output logic [AXIS_W-1:0] mem_wdata_y,
  output logic [AXIS_W-1:0] mem_wdata_z,
  output logic [AXIS_W-1:0] out_x,
  output logic [AXIS_W-1:0] out_y,
  output logic [AXIS_W-1:0] out_z,
  output logic [ADDR_W:0]   length,
  output logic [2:0]        state_o
);

  // length value at which the next write fills the RAM
  localparam logic [ADDR_W:0]   LAST   = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [AXIS_W-1:0] HOME_V = AXIS_W'(HOME);

  state_t state, state_nxt;

  logic rec_q, mem_q, rec_rise, mem_rise, tick, has_data, stop_req;
  logic wr_go, rec_entry, play_entry;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr, wr_ptr_d, rd_ptr_d, addr_d;
  logic [ADDR_W:0]   length_d;
  logic              we_d;
  logic [AXIS_W-1:0] ox_d, oy_d, oz_d, wx_d, wy_d, wz_d;

  assign rec_rise = btn_rec & ~rec_q;
  assign mem_rise = btn_mem & ~mem_q;
  assign stop_req = rec_rise | mem_rise;
  assign has_data = (length != '0);
  assign state_o  = state;

  // Button history for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rec_q <= 1'b0;
      mem_q <= 1'b0;
    end else begin
      rec_q <= btn_rec;
      mem_q <= btn_mem;
    end
  end

  // Timer restarts on every state change so each state sees a full period.
  dwell_timer #(.DWELL(DWELL)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_nxt != state),
    .en   (state == S_RECORD || state == S_HOLD),
    .tick (tick)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; enable drop overrides everything.
  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (btn_rec)                  state_nxt = S_RECORD;
          else if (btn_mem && has_data) state_nxt = S_FETCH;
          else                          state_nxt = S_LIVE;
        end
        S_LIVE: begin
          if (rec_rise)                  state_nxt = S_RECORD;
          else if (mem_rise && has_data) state_nxt = S_FETCH;
        end
        S_RECORD: begin
          if (rec_rise)                     state_nxt = S_LIVE;
          else if (tick && length == LAST)  state_nxt = S_LIVE;
        end
        S_FETCH:  state_nxt = stop_req ? S_LIVE : S_LOAD;
        S_LOAD:   state_nxt = stop_req ? S_LIVE : S_HOLD;
        S_HOLD: begin
          if (stop_req)  state_nxt = S_LIVE;
          else if (tick) state_nxt = S_FETCH;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Next values of pointers, RAM interface and setpoints.
  always_comb begin
    // a write only happens on a tick that is not also a stop/disable
    wr_go      = enable && (state == S_RECORD) && tick && !rec_rise;
    rec_entry  = (state_nxt == S_RECORD) && (state != S_RECORD);
    play_entry = (state_nxt == S_FETCH) && (state == S_LIVE || state == S_IDLE);

    wr_ptr_d = wr_ptr;
    rd_ptr_d = rd_ptr;
    length_d = length;
    we_d     = 1'b0;
    wx_d     = mem_wdata_x;
    wy_d     = mem_wdata_y;
    wz_d     = mem_wdata_z;

    if (rec_entry) begin
      wr_ptr_d = '0;
      length_d = '0;
    end
    if (wr_go) begin
      wr_ptr_d = wr_ptr + 1'b1;
      length_d = length + 1'b1;
      we_d     = 1'b1;
      wx_d     = accel_x;
      wy_d     = accel_y;
      wz_d     = accel_z;
    end

    if (play_entry)
      rd_ptr_d = '0;
    else if (state == S_HOLD && state_nxt == S_FETCH)
      rd_ptr_d = ({1'b0, rd_ptr} == length - 1'b1) ? '0 : rd_ptr + 1'b1;

    // the write pulse carries the address being written; otherwise the
    // address follows whichever pointer owns the next state
    if (wr_go)                       addr_d = wr_ptr;
    else if (state_nxt == S_RECORD)  addr_d = wr_ptr_d;
    else                             addr_d = rd_ptr_d;

    ox_d = out_x;
    oy_d = out_y;
    oz_d = out_z;
    if (state_nxt == S_IDLE || state == S_IDLE) begin
      ox_d = HOME_V;
      oy_d = HOME_V;
      oz_d = HOME_V;
    end else begin
      case (state)
        S_LIVE, S_RECORD: begin
          ox_d = accel_x;
          oy_d = accel_y;
          oz_d = accel_z;
        end
        S_LOAD: begin
          ox_d = mem_rdata_x;
          oy_d = mem_rdata_y;
          oz_d = mem_rdata_z;
        end
        default: ;
      endcase
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      length      <= '0;
      mem_addr    <= '0;
      mem_we      <= 1'b0;
      mem_wdata_x <= '0;
      mem_wdata_y <= '0;
      mem_wdata_z <= '0;
      out_x       <= HOME_V;
      out_y       <= HOME_V;
      out_z       <= HOME_V;
    end else begin
      wr_ptr      <= wr_ptr_d;
      rd_ptr      <= rd_ptr_d;
      length      <= length_d;
      mem_addr    <= addr_d;
      mem_we      <= we_d;
      mem_wdata_x <= wx_d;
      mem_wdata_y <= wy_d;
      mem_wdata_z <= wz_d;
      out_x       <= ox_d;
      out_y       <= oy_d;
      out_z       <= oz_d;
    end
  end

endmodule

// File: tb/tb_traj_sequencer.sv
// Bench for traj_sequencer with DWELL=4, ADDR_W=2 and a behavioural RAM.
module tb_traj_sequencer;

  localparam int AW = 2;
  localparam int DW = 4;

  logic clk = 1'b0;
  logic rst, enable, btn_rec, btn_mem;
  logic [7:0] accel_x, accel_y, accel_z;
  logic [7:0] mem_rdata_x, mem_rdata_y, mem_rdata_z;
  logic [AW-1:0] mem_addr;
  logic mem_we;
  logic [7:0] mem_wdata_x, mem_wdata_y, mem_wdata_z;
  logic [7:0] out_x, out_y, out_z;
  logic [AW:0] length;
  logic [2:0] state_o;

  traj_sequencer #(.ADDR_W(AW), .DWELL(DW), .HOME(50)) dut (
    .clk(clk), .rst(rst), .enable(enable), .btn_rec(btn_rec), .btn_mem(btn_mem),
    .accel_x(accel_x), .accel_y(accel_y), .accel_z(accel_z),
    .mem_rdata_x(mem_rdata_x), .mem_rdata_y(mem_rdata_y), .mem_rdata_z(mem_rdata_z),
    .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata_x(mem_wdata_x), .mem_wdata_y(mem_wdata_y), .mem_wdata_z(mem_wdata_z),
    .out_x(out_x), .out_y(out_y), .out_z(out_z),
    .length(length), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // synchronous RAM: read data valid one cycle after the address
  logic [23:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= {mem_wdata_x, mem_wdata_y, mem_wdata_z};
    {mem_rdata_x, mem_rdata_y, mem_rdata_z} <= ram[mem_addr];
  end

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0] x, y, z;
  } wr_t;

  wr_t        exp_wr[$];
  logic [7:0] exp_out[$];
  int errors = 0, checks = 0, cyc = 0, we_cyc = 0;
  bit we_seen;

  // one clock; any write strobe is drained against the write scoreboard
  task automatic step();
    wr_t e;
    @(posedge clk); #1;
    cyc++;
    we_seen = 1'b0;
    if (mem_we === 1'b1) begin
      we_seen = 1'b1;
      we_cyc  = cyc;
      checks++;
      if (exp_wr.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: got addr=%0d x=%0d at cycle %0d, required no write", mem_addr, mem_wdata_x, cyc);
      end else begin
        e = exp_wr.pop_front();
        if ({mem_addr, mem_wdata_x, mem_wdata_y, mem_wdata_z} !== e) begin
          errors++;
          $display("FAIL wr_data: got addr=%0d xyz=%0d/%0d/%0d, required addr=%0d xyz=%0d/%0d/%0d",
                   mem_addr, mem_wdata_x, mem_wdata_y, mem_wdata_z, e.addr, e.x, e.y, e.z);
        end
      end
    end
  endtask

  task automatic wait_we(input string nm);
    int n = 0;
    do begin step(); n++; end while (!we_seen && n < 12);
    checks++;
    if (!we_seen) begin errors++; $display("FAIL %s: no mem_we within 12 cycles", nm); end
  endtask

  task automatic set_accel(input logic [7:0] v);
    accel_x = v; accel_y = v + 8'd1; accel_z = v + 8'd2;
  endtask

  task automatic test_reset();
    rst = 1; enable = 0; btn_rec = 0; btn_mem = 0; set_accel(8'd0);
    #2;
    checks++;
    if ({out_x, out_y, out_z} !== {8'd50, 8'd50, 8'd50} || state_o !== 3'd0) begin
      errors++; $display("FAIL reset_out: got out=%0d/%0d/%0d state=%0d, required 50/50/50 state=0", out_x, out_y, out_z, state_o);
    end
    checks++;
    if (mem_we !== 1'b0 || mem_addr !== '0 || length !== '0 || mem_wdata_x !== 8'd0) begin
      errors++; $display("FAIL reset_mem: got we=%b addr=%0d len=%0d wd=%0d, required 0/0/0/0", mem_we, mem_addr, length, mem_wdata_x);
    end
    step(); rst = 0;
    repeat (3) step();
    checks++;
    if (state_o !== 3'd0 || out_x !== 8'd50) begin
      errors++; $display("FAIL idle_disabled: got state=%0d out_x=%0d, required 0 and 50", state_o, out_x);
    end
    enable = 1; step();
    checks++;
    if (state_o !== 3'd1) begin errors++; $display("FAIL enter_live: got state=%0d, required 1", state_o); end
    accel_x = 8'h20; step();
    checks++;
    if (out_x !== 8'h20) begin errors++; $display("FAIL live_follow: got out_x=%0h, required 20", out_x); end
  endtask

  task automatic test_record();
    int ent, prev;
    step();
    btn_rec = 1; step(); btn_rec = 0; ent = cyc;
    checks++;
    if (state_o !== 3'd2 || length !== '0) begin
      errors++; $display("FAIL rec_enter: got state=%0d len=%0d, required 2 and 0", state_o, length);
    end
    prev = ent;
    for (int k = 0; k < 3; k++) begin
      set_accel(8'((k + 1) * 10));
      exp_wr.push_back({AW'(k), 8'((k + 1) * 10), 8'((k + 1) * 10 + 1), 8'((k + 1) * 10 + 2)});
      wait_we("rec_write");
      checks++;
      if (we_cyc - prev !== DW) begin errors++; $display("FAIL rec_spacing: got %0d cycles, required %0d", we_cyc - prev, DW); end
      checks++;
      if (length !== (AW + 1)'(k + 1)) begin errors++; $display("FAIL rec_length: got %0d, required %0d", length, k + 1); end
      prev = we_cyc;
    end
    btn_rec = 1; step(); btn_rec = 0;
    checks++;
    if (state_o !== 3'd1 || length !== 3'd3) begin
      errors++; $display("FAIL rec_stop: got state=%0d len=%0d, required 1 and 3", state_o, length);
    end
    repeat (6) step();
    checks++;
    if (state_o !== 3'd1) begin errors++; $display("FAIL rec_stop_stays: got state=%0d, required 1", state_o); end
  endtask

  task automatic test_playback();
    int ent, prev_cyc, n;
    logic [7:0] prev_val, e;
    bit first;
    accel_x = 8'd0; step(); step();
    exp_out.push_back(8'd10); exp_out.push_back(8'd20);
    exp_out.push_back(8'd30); exp_out.push_back(8'd10);
    btn_mem = 1; step(); btn_mem = 0; ent = cyc;
    checks++;
    if (state_o !== 3'd3) begin errors++; $display("FAIL play_enter: got state=%0d, required 3", state_o); end
    prev_val = out_x; prev_cyc = ent; first = 1; n = 0;
    while (exp_out.size() > 0 && n < 40) begin
      step(); n++;
      if (out_x !== prev_val) begin
        e = exp_out.pop_front();
        checks++;
        if (out_x !== e) begin errors++; $display("FAIL play_value: got out_x=%0d, required %0d", out_x, e); end
        checks++;
        if (cyc - prev_cyc !== (first ? 2 : DW + 2)) begin
          errors++; $display("FAIL play_timing: got %0d cycles, required %0d", cyc - prev_cyc, first ? 2 : DW + 2);
        end
        prev_val = out_x; prev_cyc = cyc; first = 0;
      end
    end
    checks++;
    if (exp_out.size() != 0) begin errors++; $display("FAIL play_timeout: %0d values outstanding, required 0", exp_out.size()); end
    btn_mem = 1; step(); btn_mem = 0;
    checks++;
    if (state_o !== 3'd1 || length !== 3'd3) begin
      errors++; $display("FAIL play_stop: got state=%0d len=%0d, required 1 and 3", state_o, length);
    end
  endtask

  task automatic test_enable_drop();
    int n = 0;
    step();
    btn_mem = 1; step(); btn_mem = 0;
    while (state_o !== 3'd5 && n < 10) begin step(); n++; end
    checks++;
    if (state_o !== 3'd5) begin errors++; $display("FAIL hold_reach: got state=%0d, required 5", state_o); end
    enable = 0; step();
    checks++;
    if (state_o !== 3'd0 || out_x !== 8'd50 || out_z !== 8'd50 || length !== 3'd3) begin
      errors++; $display("FAIL enable_drop: got state=%0d out_x=%0d len=%0d, required 0/50/3", state_o, out_x, length);
    end
    enable = 1; step();
    checks++;
    if (state_o !== 3'd1) begin errors++; $display("FAIL reenable: got state=%0d, required 1", state_o); end
  endtask

  task automatic test_priority();
    step();
    btn_rec = 1; btn_mem = 1; step();
    checks++;
    if (state_o !== 3'd2) begin errors++; $display("FAIL both_rise: got state=%0d, required 2", state_o); end
    btn_rec = 0; btn_mem = 0; step();
    btn_rec = 1; step(); btn_rec = 0;
    checks++;
    if (state_o !== 3'd1 || length !== '0) begin
      errors++; $display("FAIL early_stop: got state=%0d len=%0d, required 1 and 0", state_o, length);
    end
    btn_mem = 1; step();
    checks++;
    if (state_o !== 3'd1) begin errors++; $display("FAIL mem_empty: got state=%0d, required 1", state_o); end
    repeat (3) step();
    checks++;
    if (state_o !== 3'd1) begin errors++; $display("FAIL mem_held_empty: got state=%0d, required 1", state_o); end
  endtask

  // btn_mem stays high throughout, so it must not trigger playback afterwards
  task automatic test_full();
    btn_rec = 1; step(); btn_rec = 0;
    checks++;
    if (state_o !== 3'd2) begin errors++; $display("FAIL full_enter: got state=%0d, required 2", state_o); end
    for (int k = 0; k < 4; k++) begin
      set_accel(8'(8'h40 + k * 4));
      exp_wr.push_back({AW'(k), 8'(8'h40 + k * 4), 8'(8'h41 + k * 4), 8'(8'h42 + k * 4)});
      wait_we("full_write");
      checks++;
      if (state_o !== (k == 3 ? 3'd1 : 3'd2) || length !== (AW + 1)'(k + 1)) begin
        errors++; $display("FAIL full_progress: got state=%0d len=%0d, required %0d and %0d", state_o, length, k == 3 ? 1 : 2, k + 1);
      end
    end
    repeat (6) step();
    checks++;
    if (state_o !== 3'd1 || length !== 3'd4) begin
      errors++; $display("FAIL full_after: got state=%0d len=%0d, required 1 and 4", state_o, length);
    end
    btn_mem = 0; step();
  endtask

  task automatic test_rst_mid_record();
    step();
    set_accel(8'h77);
    btn_rec = 1; step(); btn_rec = 0;
    exp_wr.push_back({AW'(0), 8'h77, 8'h78, 8'h79});
    wait_we("rst_rec_write");
    checks++;
    if (length !== 3'd1 || out_x !== 8'h77) begin
      errors++; $display("FAIL pre_rst: got len=%0d out_x=%0h, required 1 and 77", length, out_x);
    end
    #2 rst = 1;
    #1;
    checks++;
    if (out_x !== 8'd50 || out_y !== 8'd50 || length !== '0 || state_o !== 3'd0 || mem_we !== 1'b0) begin
      errors++; $display("FAIL async_rst: got out_x=%0d len=%0d state=%0d we=%b, required 50/0/0/0", out_x, length, state_o, mem_we);
    end
    step(); rst = 0;
    step();
    checks++;
    if (state_o !== 3'd1) begin errors++; $display("FAIL post_rst: got state=%0d, required 1", state_o); end
  endtask

  initial begin
    test_reset();
    test_record();
    test_playback();
    test_enable_drop();
    test_priority();
    test_full();
    test_rst_mid_record();
    checks++;
    if (exp_wr.size() != 0) begin errors++; $display("FAIL wr_outstanding: %0d writes missing, required 0", exp_wr.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
